// File: rtl/hamming_pkg.sv
// Purpose: shared types and constants for the (16,11) SECDED byte-stream decoder.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package hamming_pkg;

  // Controller states: two input bytes, one decode cycle, two output bytes.
  typedef enum logic [2:0] {
    IN_LO  = 3'd0,
    IN_HI  = 3'd1,
    DEC    = 3'd2,
    OUT_LO = 3'd3,
    OUT_HI = 3'd4
  } state_e;

  // Result classification carried in the top two bits of the result word.
  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_SGL  = 2'b01;
  localparam logic [1:0] FLAG_DBL  = 2'b10;

  // Codeword bit positions. Parity bits sit at the power-of-two indices,
  // the overall parity bit at index 0, data fills the remaining slots.
  localparam int POS_P0  = 0;
  localparam int POS_P1  = 1;
  localparam int POS_P2  = 2;
  localparam int POS_D1  = 3;
  localparam int POS_P4  = 4;
  localparam int POS_D2  = 5;
  localparam int POS_D4  = 7;
  localparam int POS_P8  = 8;
  localparam int POS_D5  = 9;
  localparam int POS_D11 = 15;

  // Pull d[11:1] out of a codeword, skipping the parity positions.
  function automatic logic [10:0] extract_data(input logic [15:0] cw);
    return {cw[POS_D11:POS_D5], cw[POS_D4:POS_D2], cw[POS_D1]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Purpose: combinational SECDED check of one 16-bit codeword: syndrome, overall parity, corrected data, flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [15:0] cw_i,
  output logic [3:0]  syn_o,
  output logic        par_o,
  output logic [10:0] data_o,
  output logic [1:0]  flag_o
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;
  logic [1:0]  flag;

  // Syndrome is the XOR of the indices of every set bit; parity covers all 16 bits.
  always_comb begin
    syn = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (cw_i[i]) begin
        syn = syn ^ 4'(i);
      end
    end
    par = ^cw_i;
  end

  // Odd parity means one flipped bit at index syn (index 0 is p0, so data is untouched then).
  // Even parity with a non-zero syndrome is two flips: report and pass data through uncorrected.
  always_comb begin
    fixed = cw_i;
    flag  = FLAG_NONE;
    if (par) begin
      fixed[syn] = ~cw_i[syn];
      flag       = FLAG_SGL;
    end else if (syn != 4'd0) begin
      flag = FLAG_DBL;
    end
  end

  assign syn_o  = syn;
  assign par_o  = par;
  assign data_o = extract_data(fixed);
  assign flag_o = flag;

endmodule

// File: rtl/hamming_dec_stream.sv
// Purpose: byte-stream SECDED decoder; two codeword bytes in, two result bytes {flag,3'b0,d[11:1]} out. Optional counters via HAMMING_STATS_EN.
// Latency: out_valid_o rises on the second edge after the high input byte is accepted (one DEC cycle); 5 cycles/word at full rate.
// Backpressure: in_ready_o low from DEC until the high result byte is taken; out_data_o held while out_valid_o && !out_ready_i.
module hamming_dec_stream
  import hamming_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  input  logic       out_ready_i
`ifdef HAMMING_STATS_EN
  ,
  input  logic       stat_clr_i,
  output logic [7:0] single_cnt_o,
  output logic [7:0] double_cnt_o
`endif
);

  state_e      state_q, state_d;
  logic [15:0] word_q;
  logic [15:0] result_q;

  logic [3:0]  syn;
  logic        par;
  logic [10:0] dec_data;
  logic [1:0]  dec_flag;

  hamming_syndrome u_syndrome (
    .cw_i   (word_q),
    .syn_o  (syn),
    .par_o  (par),
    .data_o (dec_data),
    .flag_o (dec_flag)
  );

  // Syndrome and parity are folded into the flag; the raw values are not needed here.
  logic unused_syn;
  assign unused_syn = ^{syn, par};

  // State register; reset abandons any partial word or pending result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IN_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: advance on each handshake, DEC always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IN_LO:   if (in_valid_i)  state_d = IN_HI;
      IN_HI:   if (in_valid_i)  state_d = DEC;
      DEC:                      state_d = OUT_LO;
      OUT_LO:  if (out_ready_i) state_d = OUT_HI;
      OUT_HI:  if (out_ready_i) state_d = IN_LO;
      default:                  state_d = IN_LO;
    endcase
  end

  // Outputs decoded from state: input and output phases never overlap.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = 8'h00;
    case (state_q)
      IN_LO, IN_HI: in_ready_o = 1'b1;
      OUT_LO: begin
        out_valid_o = 1'b1;
        out_data_o  = result_q[7:0];
      end
      OUT_HI: begin
        out_valid_o = 1'b1;
        out_data_o  = result_q[15:8];
      end
      default: ;
    endcase
  end

  // Capture codeword bytes on accept and latch the decoded result in DEC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q   <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      if (state_q == IN_LO && in_valid_i) begin
        word_q[7:0] <= in_data_i;
      end
      if (state_q == IN_HI && in_valid_i) begin
        word_q[15:8] <= in_data_i;
      end
      if (state_q == DEC) begin
        result_q <= {dec_flag, 3'b000, dec_data};
      end
    end
  end

`ifdef HAMMING_STATS_EN
  logic [7:0] single_cnt_q;
  logic [7:0] double_cnt_q;

  // Saturating per-class word counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      single_cnt_q <= 8'h00;
      double_cnt_q <= 8'h00;
    end else if (stat_clr_i) begin
      single_cnt_q <= 8'h00;
      double_cnt_q <= 8'h00;
    end else if (state_q == DEC) begin
      if (dec_flag == FLAG_SGL && single_cnt_q != 8'hFF) begin
        single_cnt_q <= single_cnt_q + 8'h01;
      end
      if (dec_flag == FLAG_DBL && double_cnt_q != 8'hFF) begin
        double_cnt_q <= double_cnt_q + 8'h01;
      end
    end
  end

  assign single_cnt_o = single_cnt_q;
  assign double_cnt_o = double_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_dec_stream.sv
// Purpose: directed and seeded-random checks of the byte-stream SECDED decoder (stats checks when HAMMING_STATS_EN is defined).
// Latency: checks the one-cycle DEC gap and the 5-cycle full-rate word time.
// Backpressure: holds out_ready low in OUT_LO and checks the output byte and in_ready stay put.
module tb_hamming_dec_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
`ifdef HAMMING_STATS_EN
  logic       stat_clr = 1'b0;
  logic [7:0] single_cnt;
  logic [7:0] double_cnt;
`endif

  hamming_dec_stream dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready)
`ifdef HAMMING_STATS_EN
    ,
    .stat_clr_i   (stat_clr),
    .single_cnt_o (single_cnt),
    .double_cnt_o (double_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed hang, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 20 && !in_ready; n++) tick();
    chk("in_ready_wait", 16'(in_ready), 16'h1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, input int gap);
    out_ready = 1'b0;
    repeat (gap) tick();
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    chk("out_valid_wait", 16'(out_valid), 16'h1);
    b = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
  endtask

  task automatic recv_word(input string tag, input logic [15:0] exp, input int gap);
    logic [7:0] lo, hi;
    recv_byte(lo, gap);
    recv_byte(hi, gap);
    chk(tag, {hi, lo}, exp);
  endtask

  // Independent encoder: place data, set p1/p2/p4/p8 to cancel the data syndrome, then overall parity.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    logic [3:0]  s;
    w = 16'h0000;
    w[3]     = d[0];
    w[7:5]   = d[3:1];
    w[15:9]  = d[10:4];
    s = 4'h0;
    for (int i = 1; i < 16; i++) if (w[i]) s = s ^ 4'(i);
    w[1] = s[0];
    w[2] = s[1];
    w[4] = s[2];
    w[8] = s[3];
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] data_of(input logic [15:0] w);
    return {w[15:9], w[7:5], w[3]};
  endfunction

  initial begin
    int c0;
    int exp_sgl;
    int exp_dbl;
    exp_sgl = 0;
    exp_dbl = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_data", 16'(out_data), 16'h0000);
`ifdef HAMMING_STATS_EN
    chk("rst_single_cnt", 16'(single_cnt), 16'h0);
    chk("rst_double_cnt", 16'(double_cnt), 16'h0);
`endif
    rst_n = 1'b1;
    tick();

    // Clean word at full rate, with DEC gap and word-time checks
    c0 = cyc;
    send_word(16'h000F, 0);
    chk("dec_out_valid_low", 16'(out_valid), 16'h0);
    chk("dec_in_ready_low", 16'(in_ready), 16'h0);
    recv_word("clean", 16'h0001, 0);
    chk("word_cycles", 16'(cyc - c0), 16'd5);

    // Single data-bit error
    send_word(16'h0007, 0);
    recv_word("single_d1", 16'h4001, 0);
`ifdef HAMMING_STATS_EN
    exp_sgl++;
    chk("single_cnt_1", 16'(single_cnt), 16'(exp_sgl));
`endif

    // p0 in error
    send_word(16'h000E, 0);
    recv_word("single_p0", 16'h4001, 0);
`ifdef HAMMING_STATS_EN
    exp_sgl++;
    chk("single_cnt_2", 16'(single_cnt), 16'(exp_sgl));
`endif

    // Double error
    send_word(16'h0027, 0);
    recv_word("double", 16'h8002, 0);
`ifdef HAMMING_STATS_EN
    exp_dbl++;
    chk("double_cnt_1", 16'(double_cnt), 16'(exp_dbl));
`endif

    // Back-pressure in OUT_LO with junk offered on the input
    send_word(16'h000F, 0);
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int n = 0; n < 7; n++) begin
      chk("bp_out_valid", 16'(out_valid), 16'h1);
      chk("bp_out_data", 16'(out_data), 16'h0001);
      chk("bp_in_ready", 16'(in_ready), 16'h0);
      tick();
    end
    in_valid = 1'b0;
    recv_word("bp_word", 16'h0001, 0);
    chk("bp_after_in_ready", 16'(in_ready), 16'h1);
    chk("bp_after_out_valid", 16'(out_valid), 16'h0);

    // Random encoded words with 0..2 flips, full rate then random gaps
    for (int k = 0; k < 15; k++) begin
      logic [10:0] d;
      logic [15:0] w, exp;
      int nf, i, j, gap;
      d  = 11'($urandom_range(0, 2047));
      nf = $urandom_range(0, 2);
      i  = $urandom_range(0, 15);
      j  = $urandom_range(0, 15);
      if (j == i) j = (i + 1 + $urandom_range(0, 14)) % 16;
      w = encode(d);
      if (nf >= 1) w[i] = ~w[i];
      if (nf == 2) w[j] = ~w[j];
      case (nf)
        0:       exp = {2'b00, 3'b000, d};
        1:       exp = {2'b01, 3'b000, d};
        default: exp = {2'b10, 3'b000, data_of(w)};
      endcase
      if (nf == 1) exp_sgl++;
      if (nf == 2) exp_dbl++;
      gap = (k < 7) ? 0 : $urandom_range(0, 3);
      send_word(w, gap);
      recv_word("random", exp, gap);
    end
`ifdef HAMMING_STATS_EN
    chk("rand_single_cnt", 16'(single_cnt), 16'(exp_sgl));
    chk("rand_double_cnt", 16'(double_cnt), 16'(exp_dbl));

    // Clear held across a corrected word: clear must beat the DEC increment
    stat_clr = 1'b1;
    send_word(16'h0007, 0);
    recv_word("clr_word", 16'h4001, 0);
    stat_clr = 1'b0;
    chk("clr_single_cnt", 16'(single_cnt), 16'h0);
    chk("clr_double_cnt", 16'(double_cnt), 16'h0);
`endif

    // Reset mid-word discards the pending low byte
    send_byte(8'h0F, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 16'(out_valid), 16'h0);
    chk("mid_rst_in_ready", 16'(in_ready), 16'h1);
    tick();
    rst_n = 1'b1;
    send_word(16'h000F, 0);
    recv_word("after_reset", 16'h0001, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
